// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: address map, access sizes,
// byte-lane mask and load-extension helpers.
package lsu_pkg;

  localparam logic [31:0] OUT_BASE  = 32'h1000_0000;
  localparam logic [31:0] IN_BASE   = 32'h1001_0000;
  localparam int          WIN_SHIFT = 12;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } lsu_size_e;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      SZ_B, SZ_BU: lane_mask = 4'b0001 << lane;
      SZ_H, SZ_HU: lane_mask = 4'b0011 << lane;
      SZ_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [2:0] size);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    ld_extend = {{24{sh[7]}}, sh[7:0]};
      SZ_H:    ld_extend = {{16{sh[15]}}, sh[15:0]};
      SZ_W:    ld_extend = word;
      SZ_BU:   ld_extend = {24'h000000, sh[7:0]};
      SZ_HU:   ld_extend = {16'h0000, sh[15:0]};
      default: ld_extend = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_param_if.sv
// Core-side load/store bus of the LSU.
interface lsu_param_if;
  logic [31:0] i_lsu_addr;
  logic [2:0]  i_funct3;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [31:0] i_st_data;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misaligned;

  modport master (output i_lsu_addr, i_funct3, i_lsu_wren, i_lsu_rden, i_st_data,
                  input  o_ld_data, o_ld_valid, o_misaligned);
  modport slave  (input  i_lsu_addr, i_funct3, i_lsu_wren, i_lsu_rden, i_st_data,
                  output o_ld_data, o_ld_valid, o_misaligned);
endinterface

// File: rtl/lsu_in_sync.sv
// Two-flop synchroniser for one 32-bit asynchronous input channel.
module lsu_in_sync (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] meta_q;
  logic [31:0] sync_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta_q <= 32'h0000_0000;
      sync_q <= 32'h0000_0000;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/lsu_param.sv
// Parametrised RV32I load-store unit: DMEM, output and synchronised input windows.
// Define LSU_MISALIGN_TRAP_EN to drop misaligned accesses and flag them on o_misaligned.
module lsu_param
  import lsu_pkg::*;
#(
  parameter int DMEM_DEPTH = 512,
  parameter int NUM_OUT    = 5,
  parameter int NUM_IN     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  lsu_param_if.slave               bus,
  input  logic [NUM_IN-1:0][31:0]  i_io_in,
  output logic [NUM_OUT-1:0][31:0] o_io_out
);
  localparam int          AW         = $clog2(DMEM_DEPTH);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH * 4);

  logic [31:0] dmem_q [DMEM_DEPTH] = '{default: 32'h0000_0000};
  logic [NUM_OUT-1:0][31:0] out_q;
  logic [NUM_IN-1:0][31:0]  sync_s;

  logic [31:0] addr_s, wdata_s, rword_s, ld_data_d, ld_data_q;
  logic [3:0]  be_s;
  logic        mis_s, block_s, dmem_hit_s, st_go_s, ld_go_s, ld_ok_s;
  logic        ld_valid_q, mis_q, mis_d;
  logic [NUM_OUT-1:0] out_sel_s;
  logic [NUM_IN-1:0]  in_sel_s;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
    lsu_in_sync u_sync (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_io_in[g]), .o_q(sync_s[g]));
  end

  assign mis_s = (((bus.i_funct3 == SZ_H) || (bus.i_funct3 == SZ_HU)) && bus.i_lsu_addr[0]) ||
                 ((bus.i_funct3 == SZ_W) && (bus.i_lsu_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_s  = bus.i_lsu_addr;
  assign block_s = mis_s;
  assign mis_d   = (bus.i_lsu_wren || bus.i_lsu_rden) && mis_s;
`else
  // Force-align: words clear [1:0], halves clear bit 0.
  always_comb begin
    addr_s = bus.i_lsu_addr;
    if (mis_s) begin
      if (bus.i_funct3 == SZ_W) addr_s[1:0] = 2'b00;
      else addr_s[0] = 1'b0;
    end else begin
      addr_s = bus.i_lsu_addr;
    end
  end
  assign block_s = 1'b0;
  assign mis_d   = 1'b0;
`endif

  // Window decode (offset bits inside a 4 KiB window alias) and read mux.
  always_comb begin
    dmem_hit_s = (addr_s < DMEM_BYTES);
    rword_s    = dmem_hit_s ? dmem_q[addr_s[AW+1:2]] : 32'h0000_0000;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_sel_s[k] = (addr_s[31:WIN_SHIFT] == OUT_BASE[31:WIN_SHIFT] + 20'(k));
      rword_s      = rword_s | ({32{out_sel_s[k]}} & out_q[k]);
    end
    for (int k = 0; k < NUM_IN; k++) begin
      in_sel_s[k] = (addr_s[31:WIN_SHIFT] == IN_BASE[31:WIN_SHIFT] + 20'(k));
      rword_s     = rword_s | ({32{in_sel_s[k]}} & sync_s[k]);
    end
  end

  assign be_s      = lane_mask(bus.i_funct3, addr_s[1:0]);
  assign wdata_s   = bus.i_st_data << {addr_s[1:0], 3'b000};
  assign st_go_s   = bus.i_lsu_wren && (be_s != 4'b0000) && !block_s;
  assign ld_go_s   = bus.i_lsu_rden && !bus.i_lsu_wren;
  assign ld_ok_s   = (be_s != 4'b0000) && !block_s && (dmem_hit_s || (|out_sel_s) || (|in_sel_s));
  assign ld_data_d = ld_go_s ? (ld_ok_s ? ld_extend(rword_s, addr_s[1:0], bus.i_funct3)
                                        : 32'h0000_0000)
                             : ld_data_q;

  // DMEM byte-lane writes; contents are not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (st_go_s && dmem_hit_s && be_s[b]) dmem_q[addr_s[AW+1:2]][8*b +: 8] <= wdata_s[8*b +: 8];
    end
  end

  // Output channel registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      out_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (st_go_s && out_sel_s[k] && be_s[b]) out_q[k][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Registered load result and status strobes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'h0000_0000;
      mis_q      <= 1'b0;
    end else begin
      ld_valid_q <= ld_go_s;
      ld_data_q  <= ld_data_d;
      mis_q      <= mis_d;
    end
  end

  assign bus.o_ld_data    = ld_data_q;
  assign bus.o_ld_valid   = ld_valid_q;
  assign bus.o_misaligned = mis_q;
  assign o_io_out         = out_q;
endmodule

// File: tb/tb_lsu_param.sv
// Scoreboard bench for lsu_param: expected load results are queued at issue and
// compared against every o_ld_valid pulse.
module tb_lsu_param;
  import lsu_pkg::*;

  localparam int NUM_OUT = 5;
  localparam int NUM_IN  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_IN-1:0][31:0]  io_in;
  logic [NUM_OUT-1:0][31:0] io_out;

  lsu_param_if bus();

  lsu_param #(.DMEM_DEPTH(512), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN)) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus), .i_io_in(io_in), .o_io_out(io_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];
  logic [31:0] got, ex;
  string       nm;

  always @(negedge clk) begin
    if (bus.o_ld_valid === 1'b1) obs_q.push_back(bus.o_ld_data);
  end

  task automatic op(input logic wr, input logic rd, input logic [31:0] a,
                    input logic [2:0] f3, input logic [31:0] d);
    @(negedge clk);
    bus.i_lsu_wren = wr;
    bus.i_lsu_rden = rd;
    bus.i_lsu_addr = a;
    bus.i_funct3   = f3;
    bus.i_st_data  = d;
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    op(1'b1, 1'b0, a, f3, d);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] e, input string n);
    op(1'b0, 1'b1, a, f3, 32'h0000_0000);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_lsu_wren = 1'b0;
    bus.i_lsu_rden = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_lsu_wren = 1'b0; bus.i_lsu_rden = 1'b0; bus.i_lsu_addr = 32'h0;
    bus.i_funct3 = 3'b000; bus.i_st_data = 32'h0; io_in = '0;
    #12;
    n_checks++; if (bus.o_ld_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.o_ld_valid); else n_pass++;
    n_checks++; if (bus.o_ld_data !== 32'h0) $display("FAIL rst_data: got %h expected 0", bus.o_ld_data); else n_pass++;
    n_checks++; if (bus.o_misaligned !== 1'b0) $display("FAIL rst_mis: got %b expected 0", bus.o_misaligned); else n_pass++;
    n_checks++; if (io_out !== '0) $display("FAIL rst_io_out: got %h expected 0", io_out); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dmem();
    st(32'h0000_0004, SZ_W, 32'h1234_5678);
    ld(32'h0000_0007, SZ_B,  32'h0000_0012, "lb_7");
    ld(32'h0000_0004, SZ_BU, 32'h0000_0078, "lbu_4");
    ld(32'h0000_0006, SZ_H,  32'h0000_1234, "lh_6");
    st(32'h0000_0101, SZ_B, 32'h0000_0080);
    ld(32'h0000_0100, SZ_W,  32'h0000_8000, "lw_100");
    ld(32'h0000_0101, SZ_B,  32'hFFFF_FF80, "lb_101");
    ld(32'h0000_0100, SZ_HU, 32'h0000_8000, "lhu_100");
    st(32'h0000_0008, 3'b111, 32'hFFFF_FFFF);
    ld(32'h0000_0008, SZ_W,  32'h0000_0000, "illegal_st_dropped");
    ld(32'h0000_0004, 3'b011, 32'h0000_0000, "illegal_ld_f3");
    ld(32'h2000_0000, SZ_W,  32'h0000_0000, "unmapped_ld");
    idle();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
  endtask

  task automatic test_io_out();
    st(32'h1000_34F0, SZ_W, 32'hEFAD_1234);
    idle();
    for (int k = 0; k < NUM_OUT; k++) begin
      n_checks++;
      if (io_out[k] !== ((k == 3) ? 32'hEFAD_1234 : 32'h0))
        $display("FAIL io_out_%0d: got %h expected %h", k, io_out[k], (k == 3) ? 32'hEFAD_1234 : 32'h0);
      else n_pass++;
    end
    ld(32'h1000_3000, SZ_W, 32'hEFAD_1234, "lw_out3");
    st(32'h1000_0002, SZ_B, 32'h0000_00AB);
    st(32'h1001_0000, SZ_W, 32'h5555_5555);
    idle();
    n_checks++; if (io_out[0] !== 32'h00AB_0000) $display("FAIL sb_out0: got %h expected 00ab0000", io_out[0]); else n_pass++;
    n_checks++; if (io_out[3] !== 32'hEFAD_1234) $display("FAIL out3_kept: got %h expected efad1234", io_out[3]); else n_pass++;
    ld(32'h1001_0000, SZ_W, 32'h0000_0000, "in_window_st_dropped");
    idle();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
  endtask

  task automatic test_io_in();
    @(negedge clk);
    io_in[1] = 32'h1023_2025;
    ld(32'h1001_1000, SZ_W, 32'h0000_0000, "in1_too_early");
    ld(32'h1001_1FFE, SZ_H, 32'h0000_1023, "lh_in1");
    ld(32'h1001_1000, SZ_B, 32'h0000_0025, "lb_in1");
    ld(32'h1001_0000, SZ_W, 32'h0000_0000, "lw_in0");
    idle();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
  endtask

  task automatic test_misalign();
    logic        exp_mis;
    logic [31:0] exp_w, exp_h;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_mis = 1'b1; exp_w = 32'h0000_0000; exp_h = 32'h0000_0000;
`else
    exp_mis = 1'b0; exp_w = 32'hDEAD_BEEF; exp_h = 32'hFFFF_BEEF;
`endif
    st(32'h0000_0202, SZ_W, 32'hDEAD_BEEF);
    idle();
    n_checks++; if (bus.o_misaligned !== exp_mis) $display("FAIL mis_st: got %b expected %b", bus.o_misaligned, exp_mis); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.o_misaligned !== 1'b0) $display("FAIL mis_pulse_end: got %b expected 0", bus.o_misaligned); else n_pass++;
    ld(32'h0000_0200, SZ_W, exp_w, "lw_200_after_mis_st");
    ld(32'h0000_0201, SZ_H, exp_h, "lh_201_mis");
    idle();
    n_checks++; if (bus.o_misaligned !== exp_mis) $display("FAIL mis_ld: got %b expected %b", bus.o_misaligned, exp_mis); else n_pass++;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
  endtask

  task automatic test_back_to_back();
    st(32'h0000_0010, SZ_W, 32'hA5A5_0001);
    ld(32'h0000_0010, SZ_W,  32'hA5A5_0001, "b2b_lw_10");
    ld(32'h0000_0004, SZ_W,  32'h1234_5678, "b2b_lw_4");
    ld(32'h0000_0013, SZ_BU, 32'h0000_00A5, "b2b_lbu_13");
    st(32'h1000_1000, SZ_W, 32'h0000_0F0F);
    ld(32'h1000_1004, SZ_W,  32'h0000_0F0F, "b2b_out1_alias");
    idle();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
  endtask

  task automatic test_conflict_reset();
    op(1'b1, 1'b1, 32'h0000_0300, SZ_W, 32'h1111_2222);
    idle();
    n_checks++; if (bus.o_ld_valid !== 1'b0) $display("FAIL wr_rd_valid: got %b expected 0", bus.o_ld_valid); else n_pass++;
    ld(32'h0000_0300, SZ_W, 32'h1111_2222, "store_won");
    idle();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++; nm = name_q.pop_front(); ex = exp_q.pop_front();
      if (obs_q.size() == 0) $display("FAIL %s: no load result, expected %h", nm, ex);
      else begin got = obs_q.pop_front(); if (got !== ex) $display("FAIL %s: got %h expected %h", nm, got, ex); else n_pass++; end
    end
    op(1'b0, 1'b1, 32'h0000_0300, SZ_W, 32'h0000_0000);
    #2 rst_n = 1'b0;
    idle();
    n_checks++; if (bus.o_ld_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", bus.o_ld_valid); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.o_ld_valid !== 1'b0) $display("FAIL rst_after_valid: got %b expected 0", bus.o_ld_valid); else n_pass++;
    n_checks++; if (io_out !== '0) $display("FAIL rst_mid_io_out: got %h expected 0", io_out); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_dmem();
    test_io_out();
    test_io_in();
    test_misalign();
    test_back_to_back();
    test_conflict_reset();
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL spurious_valid: got %0d unexpected results expected 0", obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
